// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the keyboard scan-code sequencer.
//   state_e     - sequencer FSM states
//   SC_EXT      - extended-key prefix byte
//   SC_BRK      - break (key release) prefix byte
//   ASCII_NONE  - ASCII value reported for unmapped / extended codes
//   held_code_t - {ext, code} identity of a key
package kbd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StAckLo,
    StAckHi
  } state_e;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] ASCII_NONE = 8'h00;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } held_code_t;

endpackage

// File: rtl/scancode_to_ascii.sv
// scancode_to_ascii: combinational set-2 scan code to lowercase ASCII table.
//   i_code  - scan-code byte
//   i_ext   - code carried an E0 prefix (extended keys are never mapped)
//   o_ascii - ASCII character, ASCII_NONE when unmapped
module scancode_to_ascii
  import kbd_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_ext,
  output logic [7:0] o_ascii
);

  always_comb begin
    o_ascii = ASCII_NONE;
    if (!i_ext) begin
      case (i_code)
        8'h1C: o_ascii = 8'h61; // a
        8'h32: o_ascii = 8'h62; // b
        8'h21: o_ascii = 8'h63; // c
        8'h23: o_ascii = 8'h64; // d
        8'h24: o_ascii = 8'h65; // e
        8'h2B: o_ascii = 8'h66; // f
        8'h34: o_ascii = 8'h67; // g
        8'h33: o_ascii = 8'h68; // h
        8'h43: o_ascii = 8'h69; // i
        8'h3B: o_ascii = 8'h6A; // j
        8'h42: o_ascii = 8'h6B; // k
        8'h4B: o_ascii = 8'h6C; // l
        8'h3A: o_ascii = 8'h6D; // m
        8'h31: o_ascii = 8'h6E; // n
        8'h44: o_ascii = 8'h6F; // o
        8'h4D: o_ascii = 8'h70; // p
        8'h15: o_ascii = 8'h71; // q
        8'h2D: o_ascii = 8'h72; // r
        8'h1B: o_ascii = 8'h73; // s
        8'h2C: o_ascii = 8'h74; // t
        8'h3C: o_ascii = 8'h75; // u
        8'h2A: o_ascii = 8'h76; // v
        8'h1D: o_ascii = 8'h77; // w
        8'h22: o_ascii = 8'h78; // x
        8'h35: o_ascii = 8'h79; // y
        8'h1A: o_ascii = 8'h7A; // z
        8'h45: o_ascii = 8'h30; // 0
        8'h16: o_ascii = 8'h31; // 1
        8'h1E: o_ascii = 8'h32; // 2
        8'h26: o_ascii = 8'h33; // 3
        8'h25: o_ascii = 8'h34; // 4
        8'h2E: o_ascii = 8'h35; // 5
        8'h36: o_ascii = 8'h36; // 6
        8'h3D: o_ascii = 8'h37; // 7
        8'h3E: o_ascii = 8'h38; // 8
        8'h46: o_ascii = 8'h39; // 9
        8'h29: o_ascii = 8'h20; // space
        8'h5A: o_ascii = 8'h0D; // enter
        default: o_ascii = ASCII_NONE;
      endcase
    end
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: pops bytes from the PS/2 receiver FIFO, folds E0/F0 prefixes
// into key events, tracks the held key and counts distinct presses.
//   clk, reset     - clock, synchronous active-high reset
//   kb_ready       - receiver FIFO non-empty
//   kb_data        - receiver FIFO head byte
//   kb_overflow    - receiver overflow flag
//   kb_nextdata_n  - pop request, receiver pops on its rising edge
//   en             - allow new pops
//   key_valid      - one-cycle pulse per complete key event
//   key_code/key_ext/key_release/ascii - event fields, held until next event
//   key_down       - a key is held
//   held_code      - {ext, code} of the held key
//   press_count    - distinct new presses (wraps)
//   overflow_seen  - sticky receiver overflow
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned ACK_LOW_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kb_ready,
  input  logic [7:0]       kb_data,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  input  logic             en,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic [7:0]       ascii,
  output logic             key_down,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow_seen
);

  localparam int unsigned TmrMax = (ACK_LOW_CYCLES > SETTLE_CYCLES) ? ACK_LOW_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  state_e           r_state, w_state_d;
  logic [TmrW-1:0]  r_tmr, w_tmr_d;
  logic [7:0]       r_rx_byte, w_rx_byte_d;
  logic             r_ext_f, w_ext_f_d;
  logic             r_brk_f, w_brk_f_d;
  logic             r_nextdata_n, w_nextdata_n_d;
  logic             r_key_valid, w_key_valid_d;
  logic [7:0]       r_key_code, w_key_code_d;
  logic             r_key_ext, w_key_ext_d;
  logic             r_key_release, w_key_release_d;
  logic [7:0]       r_ascii, w_ascii_d;
  logic             r_key_down, w_key_down_d;
  held_code_t       r_held, w_held_d;
  logic [CNT_W-1:0] r_press_count, w_press_count_d;
  logic             r_overflow_seen;

  held_code_t       w_ev_code;
  logic [7:0]       w_ascii;

  assign w_ev_code = {r_ext_f, r_rx_byte};

  scancode_to_ascii u_scancode_to_ascii (
    .i_code  (r_rx_byte),
    .i_ext   (r_ext_f),
    .o_ascii (w_ascii)
  );

  always_comb begin
    w_state_d       = r_state;
    w_tmr_d         = r_tmr;
    w_rx_byte_d     = r_rx_byte;
    w_ext_f_d       = r_ext_f;
    w_brk_f_d       = r_brk_f;
    w_key_valid_d   = 1'b0;
    w_key_code_d    = r_key_code;
    w_key_ext_d     = r_key_ext;
    w_key_release_d = r_key_release;
    w_ascii_d       = r_ascii;
    w_key_down_d    = r_key_down;
    w_held_d        = r_held;
    w_press_count_d = r_press_count;

    unique case (r_state)
      StIdle: begin
        if (kb_ready && en) begin
          w_rx_byte_d = kb_data;
          w_state_d   = StDecode;
        end
      end
      StDecode: begin
        w_state_d = StAckLo;
        w_tmr_d   = '0;
        if (r_rx_byte == SC_EXT) begin
          w_ext_f_d = 1'b1;
        end else if (r_rx_byte == SC_BRK) begin
          w_brk_f_d = 1'b1;
        end else begin
          w_key_valid_d   = 1'b1;
          w_key_code_d    = r_rx_byte;
          w_key_ext_d     = r_ext_f;
          w_key_release_d = r_brk_f;
          w_ascii_d       = w_ascii;
          w_ext_f_d       = 1'b0;
          w_brk_f_d       = 1'b0;
          if (!r_brk_f) begin
            // Repeat makes of the held key are auto-repeat, not new presses.
            if (!r_key_down || (r_held != w_ev_code)) begin
              w_press_count_d = r_press_count + 1'b1;
            end
            w_held_d     = w_ev_code;
            w_key_down_d = 1'b1;
          end else if (r_key_down && (r_held == w_ev_code)) begin
            w_key_down_d = 1'b0;
          end
        end
      end
      StAckLo: begin
        if (r_tmr == TmrW'(ACK_LOW_CYCLES - 1)) begin
          w_state_d = StAckHi;
          w_tmr_d   = '0;
        end else begin
          w_tmr_d = r_tmr + 1'b1;
        end
      end
      StAckHi: begin
        // Receiver needs this long to sync the pop and refresh kb_ready.
        if (r_tmr == TmrW'(SETTLE_CYCLES - 1)) begin
          w_state_d = StIdle;
          w_tmr_d   = '0;
        end else begin
          w_tmr_d = r_tmr + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_nextdata_n_d = (w_state_d != StAckLo);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= StIdle;
      r_tmr           <= '0;
      r_rx_byte       <= '0;
      r_ext_f         <= 1'b0;
      r_brk_f         <= 1'b0;
      r_nextdata_n    <= 1'b1;
      r_key_valid     <= 1'b0;
      r_key_code      <= '0;
      r_key_ext       <= 1'b0;
      r_key_release   <= 1'b0;
      r_ascii         <= '0;
      r_key_down      <= 1'b0;
      r_held          <= '0;
      r_press_count   <= '0;
      r_overflow_seen <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_tmr           <= w_tmr_d;
      r_rx_byte       <= w_rx_byte_d;
      r_ext_f         <= w_ext_f_d;
      r_brk_f         <= w_brk_f_d;
      r_nextdata_n    <= w_nextdata_n_d;
      r_key_valid     <= w_key_valid_d;
      r_key_code      <= w_key_code_d;
      r_key_ext       <= w_key_ext_d;
      r_key_release   <= w_key_release_d;
      r_ascii         <= w_ascii_d;
      r_key_down      <= w_key_down_d;
      r_held          <= w_held_d;
      r_press_count   <= w_press_count_d;
      r_overflow_seen <= r_overflow_seen | kb_overflow;
    end
  end

  assign kb_nextdata_n = r_nextdata_n;
  assign key_valid     = r_key_valid;
  assign key_code      = r_key_code;
  assign key_ext       = r_key_ext;
  assign key_release   = r_key_release;
  assign ascii         = r_ascii;
  assign key_down      = r_key_down;
  assign held_code     = r_held;
  assign press_count   = r_press_count;
  assign overflow_seen = r_overflow_seen;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: receiver FIFO model plus key-event reference model for kbd_scan_ctrl.
module tb_kbd_scan_ctrl;

  localparam int unsigned ACK    = 2;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned CW     = 8;

  logic          clk;
  logic          reset;
  logic          kb_ready;
  logic [7:0]    kb_data;
  logic          kb_overflow;
  logic          kb_nextdata_n;
  logic          en;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_release;
  logic [7:0]    ascii;
  logic          key_down;
  logic [8:0]    held_code;
  logic [CW-1:0] press_count;
  logic          overflow_seen;

  kbd_scan_ctrl #(
    .ACK_LOW_CYCLES (ACK),
    .SETTLE_CYCLES  (SETTLE),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .kb_ready      (kb_ready),
    .kb_data       (kb_data),
    .kb_overflow   (kb_overflow),
    .kb_nextdata_n (kb_nextdata_n),
    .en            (en),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_release   (key_release),
    .ascii         (ascii),
    .key_down      (key_down),
    .held_code     (held_code),
    .press_count   (press_count),
    .overflow_seen (overflow_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Key map as listed: letters a..z then digits 0..9, in this code order.
  logic [7:0] map_codes [0:35] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string map_chars = "abcdefghijklmnopqrstuvwxyz0123456789";

  function automatic logic [7:0] exp_ascii(input logic ext, input logic [7:0] c);
    if (ext) return 8'h00;
    for (int i = 0; i < 36; i++) if (map_codes[i] == c) return map_chars[i];
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  // Receiver FIFO contents, head is what the DUT sees on kb_data.
  logic [7:0] rxq[$];
  int pops  = 0;
  int n_ev  = 0;

  // Reference model state.
  logic          m_ext, m_brk, m_down;
  logic [8:0]    m_held;
  logic [CW-1:0] m_cnt;
  int            kv_since_pop;
  logic          prev_n;
  int            lo_run, hi_run;
  logic          have_rise;

  always @(negedge clk) begin
    logic [7:0] b;
    if (reset) begin
      m_ext = 0; m_brk = 0; m_down = 0; m_held = '0; m_cnt = '0;
      kv_since_pop = 0; prev_n = kb_nextdata_n; lo_run = 0; hi_run = 0; have_rise = 0;
    end else begin
      if (key_valid) begin
        kv_since_pop++;
        n_ev++;
        chk("valid_at_ack_start", {30'd0, kb_nextdata_n, prev_n}, 32'd1);
      end
      if (kb_nextdata_n) begin
        if (!prev_n) begin
          chk("ack_low_len", lo_run, ACK);
          chk("pop_nonempty", rxq.size() != 0, 1);
          if (rxq.size() != 0) begin
            b = rxq.pop_front();
            pops++;
            if (b == 8'hE0) begin
              m_ext = 1'b1;
              chk("prefix_no_valid", kv_since_pop, 0);
            end else if (b == 8'hF0) begin
              m_brk = 1'b1;
              chk("prefix_no_valid", kv_since_pop, 0);
            end else begin
              chk("event_one_valid", kv_since_pop, 1);
              chk("event_code", key_code, b);
              chk("event_ext", key_ext, m_ext);
              chk("event_release", key_release, m_brk);
              chk("event_ascii", ascii, exp_ascii(m_ext, b));
              if (!m_brk) begin
                if (!m_down || m_held != {m_ext, b}) m_cnt++;
                m_held = {m_ext, b};
                m_down = 1'b1;
              end else if (m_down && m_held == {m_ext, b}) begin
                m_down = 1'b0;
              end
              m_ext = 1'b0;
              m_brk = 1'b0;
              chk("event_key_down", key_down, m_down);
              chk("event_held_code", held_code, m_held);
              chk("event_press_count", press_count, m_cnt);
            end
          end
          kv_since_pop = 0;
          have_rise = 1'b1;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_n) begin
          if (have_rise) chk("settle_len", hi_run >= SETTLE + 2, 1);
          lo_run = 0;
        end
        lo_run++;
      end
      prev_n = kb_nextdata_n;
    end
    kb_ready = (rxq.size() != 0);
    kb_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  task automatic drain();
    int t = 0;
    while (rxq.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", rxq.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    rxq.push_back(a); rxq.push_back(b); rxq.push_back(c);
  endtask

  initial begin
    int ev0, p0, t;
    reset = 1'b1; en = 1'b1; kb_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("rst_nextdata_n", kb_nextdata_n, 1);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_ext", key_ext, 0);
    chk("rst_key_release", key_release, 0);
    chk("rst_ascii", ascii, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_held_code", held_code, 0);
    chk("rst_press_count", press_count, 0);
    chk("rst_overflow_seen", overflow_seen, 0);

    // Single tap.
    ev0 = n_ev;
    rxq.push_back(8'h1C);
    drain();
    chk("tap_make_code", key_code, 8'h1C);
    chk("tap_make_release", key_release, 0);
    chk("tap_make_ascii", ascii, 8'h61);
    chk("tap_make_down", key_down, 1);
    chk("tap_make_count", press_count, 1);
    rxq.push_back(8'hF0); rxq.push_back(8'h1C);
    drain();
    chk("tap_break_release", key_release, 1);
    chk("tap_break_down", key_down, 0);
    chk("tap_events", n_ev - ev0, 2);

    // Auto-repeat.
    do_reset();
    ev0 = n_ev;
    push3(8'h1C, 8'h1C, 8'h1C);
    drain();
    chk("rep_held", held_code, 9'h01C);
    chk("rep_count_held", press_count, 1);
    rxq.push_back(8'hF0); rxq.push_back(8'h1C);
    drain();
    chk("rep_count", press_count, 1);
    chk("rep_held_after", held_code, 9'h01C);
    chk("rep_events", n_ev - ev0, 4);

    // Extended key.
    do_reset();
    ev0 = n_ev;
    rxq.push_back(8'hE0); rxq.push_back(8'h75);
    drain();
    chk("ext_make_held", held_code, 9'h175);
    chk("ext_make_ext", key_ext, 1);
    chk("ext_make_ascii", ascii, 8'h00);
    push3(8'hE0, 8'hF0, 8'h75);
    drain();
    chk("ext_break_ext", key_ext, 1);
    chk("ext_break_down", key_down, 0);
    chk("ext_break_release", key_release, 1);
    chk("ext_events", n_ev - ev0, 2);

    // Prefix order F0 E0 and duplicate prefix.
    push3(8'hE0, 8'hE0, 8'h75);
    rxq.push_back(8'hF0); rxq.push_back(8'hE0); rxq.push_back(8'h75);
    drain();
    chk("prefix_order_down", key_down, 0);
    chk("prefix_order_count", press_count, 2);

    // Handshake timing.
    do_reset();
    @(posedge clk); #1 rxq.push_back(8'h29);
    @(negedge clk);
    @(negedge clk); chk("lat_decode_no_valid", key_valid, 0);
    @(negedge clk); chk("lat_valid", key_valid, 1);
    chk("lat_ascii", ascii, 8'h20);
    chk("lat_low0", kb_nextdata_n, 0);
    @(negedge clk); chk("lat_low1", kb_nextdata_n, 0);
    chk("lat_valid_pulse", key_valid, 0);
    @(negedge clk); chk("lat_high", kb_nextdata_n, 1);
    drain();
    p0 = pops; ev0 = n_ev;
    rxq.push_back(8'h5A); rxq.push_back(8'h45);
    drain();
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_events", n_ev - ev0, 2);

    // en dropped mid-handshake.
    push3(8'h16, 8'h1E, 8'h26);
    t = 0;
    while (kb_nextdata_n && t < 100) begin @(negedge clk); t++; end
    chk("en_reach_ack", kb_nextdata_n, 0);
    p0 = pops;
    @(posedge clk); #1 en = 1'b0;
    repeat (40) @(negedge clk);
    chk("en_pause_pops", pops - p0, 1);
    chk("en_pause_queue", rxq.size(), 2);
    chk("en_pause_idle", kb_nextdata_n, 1);
    @(posedge clk); #1 en = 1'b1;
    drain();
    chk("en_resume_ascii", ascii, 8'h33);

    // Reset mid-handshake discards the E0 already consumed.
    do_reset();
    p0 = pops;
    rxq.push_back(8'hE0); rxq.push_back(8'h1C);
    t = 0;
    while (pops == p0 && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (kb_nextdata_n && t < 100) begin @(negedge clk); t++; end
    chk("rmid_in_ack", kb_nextdata_n, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rmid_nextdata_n", kb_nextdata_n, 1);
    chk("rmid_key_valid", key_valid, 0);
    chk("rmid_key_code", key_code, 0);
    chk("rmid_key_ext", key_ext, 0);
    chk("rmid_key_down", key_down, 0);
    chk("rmid_press_count", press_count, 0);
    chk("rmid_byte_kept", rxq.size(), 1);
    @(posedge clk); #1 reset = 1'b0;
    drain();
    chk("rmid_redecode_ext", key_ext, 0);
    chk("rmid_redecode_code", key_code, 8'h1C);
    chk("rmid_redecode_count", press_count, 1);

    // Counter wrap: 2^CW alternating new presses returns the count to 0.
    do_reset();
    for (int i = 0; i < (1 << CW); i++) rxq.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
    drain();
    chk("wrap_count", press_count, 0);
    chk("wrap_held", held_code, 9'h032);

    // Sticky overflow.
    do_reset();
    chk("ovf_clear", overflow_seen, 0);
    @(posedge clk); #1 kb_overflow = 1'b1;
    @(posedge clk); #1 kb_overflow = 1'b0;
    @(negedge clk); chk("ovf_set", overflow_seen, 1);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", overflow_seen, 1);
    do_reset();
    chk("ovf_reset", overflow_seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Sequencer sitting directly behind the PS/2 receiver FIFO.
- Pops bytes via the receiver's `ready`/`nextdata_n` handshake and folds E0/F0 prefixes into whole key events.
- Tracks the currently held key, suppresses auto-repeat when counting presses, and maps set-2 scan codes to ASCII for the display path.

Parameters:
ACK_LOW_CYCLES, 2, cycles kb_nextdata_n is held low per pop (>=1)
SETTLE_CYCLES, 4, cycles kb_nextdata_n is held high after the rising edge before ready is resampled; covers receiver's 3-stage sync plus pointer update (>=4)
CNT_W, 16, width of press_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
kb_ready  in  1  receiver FIFO non-empty
kb_data  in  8  receiver FIFO head byte
kb_overflow  in  1  receiver overflow flag
kb_nextdata_n  out  1  pop request; receiver pops on its rising edge
en  in  1  allow new pops; low stops after current handshake completes
key_valid  out  1  one-cycle pulse: complete key event
key_code  out  8  final scan-code byte of event
key_ext  out  1  event carried E0 prefix
key_release  out  1  event carried F0 prefix
ascii  out  8  ASCII of event, 0x00 if unmapped or key_ext
key_down  out  1  level: a key is held
held_code  out  9  {ext,code} of held key
press_count  out  CNT_W  count of distinct new presses
overflow_seen  out  1  sticky OR of kb_overflow

Behaviour:
- Reset values: kb_nextdata_n=1, key_valid=0, key_code=0, key_ext=0, key_release=0, ascii=0, key_down=0, held_code=0, press_count=0, overflow_seen=0, prefix flags clear, state IDLE.
- FSM states: IDLE, DECODE, ACK_LO, ACK_HI.
- IDLE: if kb_ready && en, latch kb_data into rx_byte and go to DECODE. Otherwise stay.
- DECODE (1 cycle), per rx_byte:
  - 0xE0: set ext_f.
  - 0xF0: set brk_f.
  - Otherwise: register event outputs, pulse key_valid, clear both flags.
  - Always go to ACK_LO.
- Latency: key_valid is high exactly in the 2nd cycle after the IDLE cycle that sampled kb_ready=1, coincident with the first ACK_LO cycle. Event outputs hold until the next event.
- ACK_LO: kb_nextdata_n=0 for ACK_LOW_CYCLES cycles, then ACK_HI.
- ACK_HI: kb_nextdata_n=1 for SETTLE_CYCLES cycles, then IDLE. kb_ready is never sampled inside the settle window.
- Prefix bytes consume a full handshake but produce no key_valid.
- Duplicate prefix is idempotent. Prefix order (E0 F0 or F0 E0) is irrelevant.
- Make event (brk_f=0):
  - If !key_down or held_code!={ext_f,rx_byte}: press_count += 1.
  - In all cases: held_code={ext_f,rx_byte}, key_down=1.
  - Auto-repeat of the held key is not counted.
- Break event (brk_f=1):
  - If key_down and held_code matches: key_down=0, held_code unchanged.
  - Non-matching break: emits key_valid, leaves key state untouched.
- press_count wraps from all-ones to 0, no saturation.
- ASCII map (non-ext only, lowercase):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Other: 29 space (0x20), 5A 0x0D.
  - All else 0x00. ascii is valid on break events too.
- en deasserted mid-handshake: current DECODE/ACK completes, then the FSM holds in IDLE. Prefix flags are retained across the pause.
- Reset mid-handshake: return to reset values immediately, kb_nextdata_n=1. The unpopped byte stays in the receiver and is re-read after reset; any partial prefix state is discarded.
- overflow_seen is set on any cycle with kb_overflow=1 and is cleared only by reset.

Decomposition:
- Package kbd_pkg: state enum; constants SC_EXT=8'hE0, SC_BRK=8'hF0, ASCII_NONE=8'h00; held-code struct {ext, code}.
- One sub-module: scancode_to_ascii, a combinational 8-bit code plus ext bit to 8-bit ASCII case table, instantiated once on rx_byte.

Test Plan:
- Single tap: FIFO bytes 1C, F0, 1C -> two key_valid pulses. First: code 1C, release=0, ascii 0x61, key_down=1, press_count=1. Second: release=1, key_down=0.
- Auto-repeat: bytes 1C,1C,1C,F0,1C -> press_count=1, held_code=0x01C throughout, four key_valid pulses.
- Extended: bytes E0,75,E0,F0,75 -> two key_valid pulses, both key_ext=1, ascii=0x00, held_code=0x175 then key_down=0. No key_valid on any prefix byte.
- Handshake timing: kb_ready high with 0x29 -> key_valid exactly 2 cycles later, ascii=0x20. kb_nextdata_n low for 2 cycles, then high at least 4 cycles before kb_ready is resampled. Back-to-back bytes yield exactly one pop each.
- en/reset: drop en during ACK_LO -> handshake finishes, no further pops while en=0. Assert reset during ACK_LO -> kb_nextdata_n=1 next cycle, all outputs at reset values, and the byte is re-decoded after release.
- Wrap and overflow: preload 0xFFFF presses (alternating 1C/32 makes) -> next new press gives press_count=0. Pulse kb_overflow for 1 cycle -> overflow_seen stays 1 until reset.
